// File: rtl/ntt_radix_ct_out_serializer.sv
// NTT radix-R Cooley-Tukey output serializer.
// Buffers R-coefficient butterfly vectors and streams them as OUT_NB-wide beats.
module ntt_radix_ct_out_serializer #(
    parameter int R      = 8,
    parameter int OP_W   = 32,
    parameter int OUT_NB = 2,
    parameter int DEPTH  = 4,
    parameter int SIDE_W = 1
) (
    input  logic                   clk,
    input  logic                   s_rst_n,
    input  logic [R*OP_W-1:0]      in_x,
    input  logic                   in_avail,
    input  logic [SIDE_W-1:0]      in_side,
    output logic [OUT_NB*OP_W-1:0] out_data,
    output logic                   out_vld,
    input  logic                   out_rdy,
    output logic                   out_last,
    output logic [SIDE_W-1:0]      out_side,
    output logic                   full,
    output logic                   error_ovf
);

    localparam int BEAT_NB = R / OUT_NB;
    localparam int BEAT_W  = OUT_NB * OP_W;
    localparam int PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW      = $clog2(DEPTH + 1);
    localparam int BW      = (BEAT_NB > 1) ? $clog2(BEAT_NB) : 1;

    localparam logic [PW-1:0] PTR_MAX = PW'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);
    localparam logic [BW-1:0] BC_MAX  = BW'(BEAT_NB - 1);

    logic [R*OP_W-1:0] mem_x [DEPTH];
    logic [SIDE_W-1:0] mem_s [DEPTH];

    logic [PW-1:0] wp;
    logic [PW-1:0] rp;
    logic [CW-1:0] count;
    logic [BW-1:0] bc;

    logic [PW-1:0] wp_inc;
    logic [PW-1:0] rp_inc;
    logic [R*OP_W-1:0] cur_x;

    logic fire;
    logic pop;
    logic wr;
    logic ovf;

    assign out_vld  = (count != '0);
    assign out_last = out_vld && (bc == BC_MAX);
    assign full     = (count == CNT_MAX);

    assign fire = out_vld && out_rdy;
    assign pop  = fire && out_last;
    assign wr   = in_avail && (!full || pop);
    assign ovf  = in_avail && full && !pop;

    assign wp_inc = (wp == PTR_MAX) ? '0 : wp + PW'(1);
    assign rp_inc = (rp == PTR_MAX) ? '0 : rp + PW'(1);

    assign cur_x    = mem_x[rp];
    assign out_side = mem_s[rp];

    // Select the current beat out of the head vector.
    always_comb begin
        out_data = '0;
        for (int b = 0; b < BEAT_NB; b++) begin
            if (bc == BW'(b)) begin
                out_data = cur_x[b*BEAT_W +: BEAT_W];
            end
        end
    end

    // Vector storage; contents are meaningless until written.
    always_ff @(posedge clk) begin
        if (wr) begin
            mem_x[wp] <= in_x;
            mem_s[wp] <= in_side;
        end
    end

    // Write pointer advances on each accepted vector.
    always_ff @(posedge clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            wp <= '0;
        end else if (wr) begin
            wp <= wp_inc;
        end
    end

    // Beat counter and read pointer walk the head vector.
    always_ff @(posedge clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            bc <= '0;
            rp <= '0;
        end else if (fire) begin
            if (bc == BC_MAX) begin
                bc <= '0;
                rp <= rp_inc;
            end else begin
                bc <= bc + BW'(1);
            end
        end
    end

    // Occupancy tracks writes against whole-vector pops.
    always_ff @(posedge clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            count <= '0;
        end else begin
            unique case ({wr, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Sticky flag for a vector dropped on a full buffer.
    always_ff @(posedge clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            error_ovf <= 1'b0;
        end else if (ovf) begin
            error_ovf <= 1'b1;
        end
    end

endmodule
